// File: rtl/sample_capture_buf.sv
// Capture buffer: after arm, records DEPTH strobed samples of din, then streams them out oldest first.
// Optional macro THRESH_TRIG_EN: capture starts only on a strobe whose saturated |din| reaches THRESH.
module sample_capture_buf #(
    parameter int DW     = 18,
    parameter int AW     = 8,
    parameter int THRESH = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sam_clk_en,
    input  logic [DW-1:0] din,
    input  logic          arm,
    input  logic          abort,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          capt_done
);

    localparam int DEPTH = 2 ** AW;
`ifdef THRESH_TRIG_EN
    localparam bit THRESH_ON = 1'b1;
`else
    localparam bit THRESH_ON = 1'b0;
`endif
    localparam logic [DW-1:0] THRESH_W = DW'(THRESH);
    localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAX_POS  = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, PREFETCH, STREAM} state_t;

    state_t        state_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] din_mag;
    logic          trig;
    logic          wr_en;
    logic          xfer;

    // Saturating magnitude: the most negative code has no positive twin.
    always_comb begin
        din_mag = din;
        if (din[DW-1]) begin
            if (din == MIN_NEG) din_mag = MAX_POS;
            else                din_mag = -din;
        end
    end

    assign trig        = sam_clk_en && (!THRESH_ON || (din_mag >= THRESH_W));
    assign wr_en       = !reset && !abort &&
                         (((state_reg == ARMED) && trig) || ((state_reg == CAPTURE) && sam_clk_en));
    assign xfer        = out_valid && out_ready;
    assign rd_ptr_next = rd_ptr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            capt_done  <= 1'b0;
        end else begin
            capt_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (arm) begin
                        state_reg <= ARMED;
                        busy      <= 1'b1;
                    end
                end
                ARMED: begin
                    if (trig) begin
                        wr_ptr_reg <= AW'(1);
                        state_reg  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (sam_clk_en) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        if (wr_ptr_reg == '1) begin
                            state_reg <= PREFETCH;
                            capt_done <= 1'b1;
                        end
                    end
                end
                PREFETCH: begin
                    rd_ptr_reg <= '0;
                    out_data   <= mem[0];
                    out_valid  <= 1'b1;
                    out_last   <= 1'b0;
                    state_reg  <= STREAM;
                end
                STREAM: begin
                    // Next word is read on the transfer edge so beats stay back-to-back.
                    if (xfer) begin
                        if (out_last) begin
                            state_reg  <= IDLE;
                            busy       <= 1'b0;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            rd_ptr_reg <= '0;
                        end else begin
                            rd_ptr_reg <= rd_ptr_next;
                            out_data   <= mem[rd_ptr_next];
                            out_last   <= (rd_ptr_next == '1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
